// File: rtl/apb_pkg.sv
// Shared APB types and default widths for the APB requester and its response FIFO.
package apb_pkg;
  localparam int ADDR_WIDTH          = 10;
  localparam int DATA_WIDTH          = 32;
  localparam int STRB_WIDTH          = DATA_WIDTH / 8;
  localparam int APB_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } apb_rsp_t;
endpackage

// File: rtl/apb_rsp_fifo.sv
// Two-entry response FIFO; the head reads as all-zero while the FIFO is empty.
module apb_rsp_fifo
  import apb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  apb_rsp_t   data_i,
  input  logic       pop_i,
  output apb_rsp_t   data_o,
  output logic [1:0] count_o
);
  apb_rsp_t [1:0] mem_q;
  logic           wr_q, rd_q;
  logic [1:0]     cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) rd_q <= ~rd_q;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o  = (cnt_q != 2'd0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command stream into IDLE/SETUP/ACCESS transfers
// and returns one buffered response per command, with a PREADY watchdog.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = apb_pkg::DATA_WIDTH,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  apb_state_t            state_q, state_d;
  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [1:0]            count;
  logic                  expire, completing, pop, accept;
  apb_rsp_t              rsp_in, rsp_head;

  // Expiry fires on the cycle the counter would reach the limit, so the
  // transfer spends exactly TIMEOUT_CYCLES cycles in ACCESS.
  assign expire     = (TIMEOUT_CYCLES != 0) && (state_q == ACCESS) && !PREADY && (wd_q == WD_LAST);
  assign completing = (state_q == ACCESS) && (PREADY || expire);
  assign pop        = rsp_valid && rsp_ready;
  assign cmd_ready  = PRESETn &&
                      (((state_q == IDLE) && ((count != 2'd2) || pop)) ||
                       (completing && ((count == 2'd0) || ((count == 2'd1) && pop))));
  assign accept     = cmd_valid && cmd_ready;

  assign rsp_in.rdata   = (PREADY && !pwrite_q) ? PRDATA : '0;
  assign rsp_in.slverr  = PREADY ? PSLVERR : 1'b1;
  assign rsp_in.timeout = !PREADY;

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    wd_d      = wd_q;
    case (state_q)
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (completing) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end else if (TIMEOUT_CYCLES != 0) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Accept only happens in IDLE or on completion, and overrides the exit above.
    if (accept) begin
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = cmd_write;
      paddr_d   = cmd_addr;
      pwdata_d  = cmd_wdata;
      pstrb_d   = cmd_write ? cmd_strb : '0;
      wd_d      = '0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      wd_q      <= wd_d;
    end
  end

  apb_rsp_fifo u_rsp_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .push_i  (completing),
    .data_i  (rsp_in),
    .pop_i   (pop),
    .data_o  (rsp_head),
    .count_o (count)
  );

  assign rsp_valid   = (count != 2'd0);
  assign rsp_rdata   = rsp_head.rdata;
  assign rsp_slverr  = rsp_head.slverr;
  assign rsp_timeout = rsp_head.timeout;

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PSTRB   = pstrb_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: APB slave with scripted wait states and a
// command-order response model built from a plain memory array.
module tb_apb_master_bridge;
  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [9:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY = 1'b0, PSLVERR = 1'b0;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA, PRDATA = '0;
  logic [3:0]  PSTRB;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  typedef struct { bit w; logic [9:0] a; logic [31:0] d; logic [3:0] s; int wt; } cmd_t;
  typedef struct { logic [31:0] rdata; logic slverr; logic to; } exp_t;

  cmd_t        sq[$];
  exp_t        expq[$];
  logic [31:0] mmem [0:1023];
  logic [31:0] smem [0:1023];
  int          n_chk = 0, n_err = 0, cyc = 0, n_acc = 0, acc_cyc = 0, pop_cyc = 0;
  bit          have_cmd = 0, in_acc = 0;
  cmd_t        pc, cur;
  int          wcnt = 0, acc_cnt = 0;
  logic [46:0] cap;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic new_cmd(input bit w, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int wt);
    pc.w = w; pc.a = a; pc.d = d; pc.s = s; pc.wt = wt;
    have_cmd = 1;
  endtask

  task automatic rand_cmd();
    new_cmd(1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)), $urandom,
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3)));
  endtask

  // Reference: a response is fully determined when the command is accepted.
  task automatic model_accept();
    exp_t e;
    if (pc.wt >= 16) begin
      e.rdata = '0; e.slverr = 1; e.to = 1;
    end else begin
      e.rdata  = pc.w ? 32'h0 : mmem[pc.a];
      e.slverr = (pc.a[3:0] == 4'h5);
      e.to     = 0;
      if (pc.w && !e.slverr)
        for (int b = 0; b < 4; b++)
          if (pc.s[b]) mmem[pc.a][8*b +: 8] = pc.d[8*b +: 8];
    end
    expq.push_back(e);
    sq.push_back(pc);
    have_cmd = 0;
    n_acc++;
    acc_cyc = cyc;
  endtask

  // APB slave: called once per low phase, reacts to the registered bus outputs.
  task automatic slave();
    if (!(PSEL && PENABLE) && in_acc) begin
      if (cur.wt >= 16) chk("wd_len", acc_cnt, 16);
      else              chk("acc_len", acc_cnt, cur.wt + 1);
      if (sq.size() == 0) chk("idle_after", PSEL, 0);
      in_acc = 0;
    end
    PREADY = 0; PSLVERR = 1'($urandom); PRDATA = $urandom;
    if (PSEL && !PENABLE) begin
      chk("setup_q", sq.size() > 0, 1);
      if (sq.size() > 0) begin
        cur = sq.pop_front();
        chk("paddr", PADDR, cur.a);
        chk("pwrite", PWRITE, cur.w);
        chk("pstrb", PSTRB, cur.w ? cur.s : 4'h0);
        if (cur.w) chk("pwdata", PWDATA, cur.d);
      end
      cap = {PADDR, PWRITE, PWDATA, PSTRB};
      wcnt = 0; acc_cnt = 0;
    end else if (PSEL && PENABLE) begin
      in_acc = 1;
      acc_cnt++;
      chk("stable", {PADDR, PWRITE, PWDATA, PSTRB}, cap);
      if (wcnt == cur.wt) begin
        PREADY = 1;
        PSLVERR = (PADDR[3:0] == 4'h5);
        if (!PWRITE) PRDATA = smem[PADDR];
        else if (!PSLVERR)
          for (int b = 0; b < 4; b++)
            if (PSTRB[b]) smem[PADDR][8*b +: 8] = PWDATA[8*b +: 8];
      end else begin
        wcnt++;
      end
    end
  endtask

  task automatic step(input int gen, input int rr);
    exp_t e;
    @(negedge PCLK);
    cyc++;
    slave();
    if (!have_cmd && ($urandom_range(0, 99) < gen)) rand_cmd();
    cmd_valid = have_cmd; cmd_write = pc.w; cmd_addr = pc.a; cmd_wdata = pc.d; cmd_strb = pc.s;
    rsp_ready = ($urandom_range(0, 99) < rr);
    #1;
    if (rsp_valid && rsp_ready) begin
      chk("rsp_q", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_slverr", rsp_slverr, e.slverr);
        chk("rsp_timeout", rsp_timeout, e.to);
      end
      pop_cyc = cyc;
    end
    if (cmd_valid && cmd_ready) model_accept();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (expq.size() > 0 || sq.size() > 0 || have_cmd); i++) step(0, 100);
    chk("drain_q", expq.size() + sq.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESETn = 0; PREADY = 0; cmd_valid = 1; rsp_ready = 1;
    #1 chk("rst_cmd_ready", cmd_ready, 0);
    @(negedge PCLK);
    chk("rst_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB}, 0);
    chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}, 0);
    PRESETn = 1; cmd_valid = 0;
    have_cmd = 0; in_acc = 0;
    sq.delete(); expq.delete();
  endtask

  initial begin
    int base, issued, psel_hi;
    for (int i = 0; i < 1024; i++) begin mmem[i] = '0; smem[i] = '0; end
    do_reset();

    // zero-wait write and its latency
    new_cmd(1, 10'h020, 32'hDEADBEEF, 4'hF, 0);
    step(0, 100); chk("lat_accept", n_acc, 1);
    step(0, 100); chk("lat_psel", PSEL, 1); chk("lat_pen0", PENABLE, 0);
    step(0, 100); chk("lat_pen1", PENABLE, 1);
    step(0, 100); chk("lat_rsp", pop_cyc - acc_cyc, 3);

    // read back with two wait states, then a slave-error write
    new_cmd(0, 10'h020, 32'h0, 4'hF, 2);
    for (int i = 0; i < 8; i++) step(0, 100);
    new_cmd(1, 10'h005, 32'h12345678, 4'hF, 0);
    for (int i = 0; i < 6; i++) step(0, 100);

    // three back-to-back zero-wait commands
    base = n_acc; issued = 0; psel_hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (!have_cmd && issued < 3) begin rand_cmd(); pc.wt = 0; issued++; end
      step(0, 100);
      if (i >= 1) psel_hi += int'(PSEL);
    end
    chk("b2b_acc", n_acc - base, 3);
    chk("b2b_psel", psel_hi, 6);
    drain();

    // response backpressure
    base = n_acc; issued = 0;
    for (int i = 0; i < 20; i++) begin
      if (!have_cmd && issued < 4) begin rand_cmd(); pc.wt = 0; issued++; end
      step(0, 0);
    end
    chk("bp_acc", n_acc - base, 2);
    chk("bp_ready", cmd_ready, 0);
    chk("bp_psel", PSEL, 0);
    chk("bp_valid", rsp_valid, 1);
    step(0, 100);
    for (int i = 0; i < 10; i++) begin
      if (!have_cmd && issued < 4) begin rand_cmd(); pc.wt = 0; issued++; end
      step(0, 0);
    end
    chk("bp_one", n_acc - base, 3);
    drain();

    // randomized traffic
    for (int i = 0; i < 1500; i++) step(60, 70);
    drain();

    // watchdog abort
    new_cmd(1, 10'h030, 32'hCAFEF00D, 4'hF, 20);
    for (int i = 0; i < 22; i++) step(0, 100);
    drain();

    // reset in the middle of an ACCESS phase
    new_cmd(0, 10'h020, 32'h0, 4'h0, 20);
    for (int i = 0; i < 6; i++) step(0, 100);
    chk("mid_access", PENABLE, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 100);
    chk("post_rst_idle", {PSEL, rsp_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
